// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake on both sides.
// Default build: one entry, in_ready = !out_valid || out_ready (combinational).
// With PIPE_STAGE_SKID_BUF_EN defined: two entries (head + skid). in_ready then
// depends only on the skid valid flop, which removes the out_ready->in_ready path.
// A flush squashes every held entry. It takes priority over accept and drain.
// While out_valid is low, out_ctrl reads as zero, so a bubble acts as a NOP.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 133,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;

  logic accept;
  logic drain;

  assign accept = in_valid & in_ready;
  assign drain  = head_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_BUF_EN

  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Upstream sees only the skid flop. The skid absorbs the one entry that arrives
  // after the head stalls.
  assign in_ready  = ~skid_valid_q;
  assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};

  // Next-state: refill the head from the skid on drain, else spill a new entry into the skid.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_ctrl_d  = head_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      // Payload is left stale on purpose; only the valid flags matter.
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // in_ready is low whenever the skid is full, so no accept can happen here.
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        head_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else begin
        head_valid_d = accept;
        if (accept) begin
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
        end
      end
    end else if (accept) begin
      if (head_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_ctrl_d  = in_ctrl;
      end else begin
        head_valid_d = 1'b1;
        head_data_d  = in_data;
        head_ctrl_d  = in_ctrl;
      end
    end
  end

  // State register for the skid entry; an asynchronous reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

`else

  // Single entry: accept when empty or draining this cycle.
  assign in_ready  = ~head_valid_q | out_ready;
  assign occupancy = {1'b0, head_valid_q};

  // Next-state: load on accept, which also covers accept together with drain;
  // otherwise empty on drain.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_ctrl_d  = head_ctrl_q;
    if (flush) begin
      head_valid_d = 1'b0;
    end else if (accept) begin
      head_valid_d = 1'b1;
      head_data_d  = in_data;
      head_ctrl_d  = in_ctrl;
    end else if (drain) begin
      head_valid_d = 1'b0;
    end
  end

`endif

  // State register for the head entry; an asynchronous reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_ctrl_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_ctrl_q  <= head_ctrl_d;
    end
  end

  // Outputs: control bits are masked during bubbles so downstream sees a NOP.
  always_comb begin
    out_valid = head_valid_q;
    out_data  = head_data_q;
    out_ctrl  = head_valid_q ? head_ctrl_q : '0;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. The expected values are hand-computed.
// Where the two modes differ, PIPE_STAGE_SKID_BUF_EN selects the expectations.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 133;
  localparam int unsigned CW = 8;
  localparam logic [135:0] PatA5 = {17{8'hA5}};

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int n_vec = 0;
  int n_err = 0;

`ifdef PIPE_STAGE_SKID_BUF_EN
  localparam logic [1:0] FullOcc = 2'd2;
`else
  localparam logic [1:0] FullOcc = 2'd1;
`endif

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [7:0] b);
    return {{(DW-8){1'b0}}, b};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_ctrl !== 8'h00) begin n_err++; $display("FAIL rst_out_ctrl: got %h want 00", out_ctrl); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    @(posedge clk);
    step();
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_transfer;
    logic [DW-1:0] d;
    d = PatA5[DW-1:0];
    in_valid = 1'b1; in_data = d; in_ctrl = 8'h81; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_vec++; if (out_ctrl !== 8'h81) begin n_err++; $display("FAIL single_ctrl: got %h want 81", out_ctrl); end
    n_vec++; if (out_data !== d) begin n_err++; $display("FAIL single_data: got %h want %h", out_data, d); end
    n_vec++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
    n_vec++; if (out_ctrl !== 8'h00) begin n_err++; $display("FAIL bubble_ctrl: got %h want 00", out_ctrl); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = mk(8'(i)); in_ctrl = 8'(i);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      n_vec++; if (out_data !== mk(8'(i))) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, mk(8'(i))); end
      n_vec++; if (out_ctrl !== 8'(i)) begin n_err++; $display("FAIL b2b_ctrl[%0d]: got %h want %h", i, out_ctrl, 8'(i)); end
    end
    in_valid = 1'b0;
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall;
    logic [7:0] cur;
    logic       acc;
    logic       exp_rdy [3];
    logic [1:0] exp_occ [3];
`ifdef PIPE_STAGE_SKID_BUF_EN
    exp_rdy = '{1'b1, 1'b1, 1'b0};
    exp_occ = '{2'd1, 2'd2, 2'd2};
`else
    exp_rdy = '{1'b1, 1'b0, 1'b0};
    exp_occ = '{2'd1, 2'd1, 2'd1};
`endif
    out_ready = 1'b0;
    cur = 8'h11;
    in_valid = 1'b1; in_data = mk(cur); in_ctrl = cur;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (in_ready !== exp_rdy[c]) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy[c]); end
      acc = in_ready;
      step();
      if (acc) begin cur = cur + 8'h11; in_data = mk(cur); in_ctrl = cur; end
      n_vec++; if (occupancy !== exp_occ[c]) begin n_err++; $display("FAIL stall_occ[%0d]: got %0d want %0d", c, occupancy, exp_occ[c]); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_valid); end
      n_vec++; if (out_data !== mk(8'h11)) begin n_err++; $display("FAIL stall_data[%0d]: got %h want 11", c, out_data); end
      n_vec++; if (out_ctrl !== 8'h11) begin n_err++; $display("FAIL stall_ctrl[%0d]: got %h want 11", c, out_ctrl); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
`ifdef PIPE_STAGE_SKID_BUF_EN
    n_vec++; if (out_data !== mk(8'h22)) begin n_err++; $display("FAIL stall_skid_data: got %h want 22", out_data); end
    n_vec++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stall_skid_occ: got %0d want 1", occupancy); end
    step();
`endif
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty_valid: got %b want 0", out_valid); end
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stall_empty_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(8'h44); in_ctrl = 8'h44;
    step();
    in_data = mk(8'h55); in_ctrl = 8'h55;
    step();
    n_vec++; if (occupancy !== FullOcc) begin n_err++; $display("FAIL flush_pre_occ: got %0d want %0d", occupancy, FullOcc); end
    flush = 1'b1; in_data = mk(8'h66); in_ctrl = 8'h66; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_vec++; if (out_ctrl !== 8'h00) begin n_err++; $display("FAIL flush_ctrl: got %h want 00", out_ctrl); end
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(8'h77); in_ctrl = 8'h77;
    step();
    in_data = mk(8'h88); in_ctrl = 8'h88;
    step();
    n_vec++; if (occupancy !== FullOcc) begin n_err++; $display("FAIL arst_pre_occ: got %0d want %0d", occupancy, FullOcc); end
    #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_ctrl !== 8'h00) begin n_err++; $display("FAIL arst_ctrl: got %h want 00", out_ctrl); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL arst_data: got %h want 0", out_data); end
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
    step();
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_no_survivor: got %b want 0", out_valid); end
    n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL arst_post_occ: got %0d want 0", occupancy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_transfer();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
